ld_reg_arb: RTL and testbench

LD_REG_ARB -- requirements
Module: ld_reg_arb

---
 rtl/ld_reg_arb_pkg.sv | 20 ++
 rtl/ld_reg_arb_rr_pick.sv | 33 +++
 rtl/ld_reg_arb.sv | 121 ++++++++++++
 tb/tb_ld_reg_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_reg_arb_pkg.sv
// ld_reg_arb_pkg -- shared definitions for the load-register arbiter.
//   state_t       : arbiter FSM encoding (IDLE / GRANT / HOLD)
//   DEF_NREQ      : default number of requesters
//   DEF_W         : default data width of the shared load register
//   DEF_HOLD_CYC  : default idle cycles inserted after each write
//   CNT_W         : hold counter width (covers HOLD_CYC up to 15)
package ld_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_W        = 16;
  localparam int DEF_HOLD_CYC = 2;
  localparam int CNT_W        = 4;

endpackage

// File: rtl/ld_reg_arb_rr_pick.sv
// rr_pick -- combinational round-robin selector.
//   req     : request vector, bit i = requester i
//   rr_ptr  : first index to consider
//   sel     : first set request at or after rr_ptr, scanning upward mod NREQ
//   any_req : high when at least one request bit is set
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    any_req
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = IW'((int'(rr_ptr) + off) % NREQ);
      if (req[idx]) begin
        sel     = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ld_reg_arb.sv
// ld_reg_arb -- round-robin arbiter granting NREQ requesters write access
// to one shared load register, with a fixed idle gap after every write.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   req    : per-requester write request
//   din    : per-requester data, requester i at [i*W +: W]
//   gnt    : one-hot write acknowledge (one cycle)
//   gnt_id : index of the last granted requester
//   ld     : load enable to the shared register (one cycle)
//   d      : data to the shared register, held after the write
//   busy   : high whenever the arbiter is not idle
module ld_reg_arb
  import ld_reg_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int W        = DEF_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       din,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    ld,
  output logic [W-1:0]            d,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);

  state_t            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [IW-1:0]     gnt_id_q;
  logic              ld_q;
  logic [W-1:0]      d_q;
  logic              busy_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [IW-1:0]     sel;
  logic              any_req;
  logic [IW-1:0]     rr_ptr_d;
  logic [NREQ-1:0]   gnt_d;
  logic [W-1:0]      din_a [NREQ];

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .sel     (sel),
    .any_req (any_req)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_din
    assign din_a[i] = din[i*W +: W];
  end

  // Explicit wrap so non-power-of-two NREQ also returns to 0.
  always_comb begin
    rr_ptr_d = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
    gnt_d    = '0;
    gnt_d[sel] = 1'b1;
  end

  // Requests are only sampled in IDLE; GRANT and HOLD ignore req and din.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ld_q     <= 1'b0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= GRANT;
            d_q      <= din_a[sel];
            gnt_q    <= gnt_d;
            gnt_id_q <= sel;
            ld_q     <= 1'b1;
            busy_q   <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        GRANT: begin
          state_q <= HOLD;
          ld_q    <= 1'b0;
          gnt_q   <= '0;
          cnt_q   <= CNT_W'(HOLD_CYC);
        end
        HOLD: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ld_q    <= 1'b0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign ld     = ld_q;
  assign d      = d_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ld_reg_arb.sv
// tb_ld_reg_arb -- bench for ld_reg_arb: directed scenarios plus random
// traffic against a schedule-based reference model.
module tb_ld_reg_arb;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int HC = 2;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req   = '0;
  logic [N*W-1:0]    din   = '0;
  logic [N-1:0]      gnt;
  logic [1:0]        gnt_id;
  logic              ld;
  logic [W-1:0]      d;
  logic              busy;

  always #5 clk = ~clk;

  ld_reg_arb #(.NREQ(N), .W(W), .HOLD_CYC(HC)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .din    (din),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .ld     (ld),
    .d      (d),
    .busy   (busy)
  );

  // The shared load register the arbiter writes into.
  logic [W-1:0] q_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_reg <= '0;
    else if (ld) q_reg <= d;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a write is issued at edge e when the arbiter is free;
  // it then stays busy through edge e+HC and is free again at edge e+HC+2.
  int           e;
  int           free_at;
  int           busy_end;
  int           ptr;
  logic         m_ld;
  logic [N-1:0] m_gnt;
  int           m_id;
  logic [W-1:0] m_d;
  logic [W-1:0] m_q;

  task automatic m_reset();
    free_at  = e;
    busy_end = e - 1;
    ptr      = 0;
    m_ld     = 1'b0;
    m_gnt    = '0;
    m_id     = 0;
    m_d      = '0;
    m_q      = '0;
  endtask

  task automatic m_edge(input logic [N-1:0] r, input logic [N*W-1:0] dv);
    int s;
    if (m_ld) m_q = m_d;
    m_ld  = 1'b0;
    m_gnt = '0;
    s = -1;
    if (e >= free_at) begin
      for (int off = 0; off < N; off++) begin
        if (s < 0 && r[(ptr + off) % N]) s = (ptr + off) % N;
      end
    end
    if (s >= 0) begin
      m_ld     = 1'b1;
      m_gnt    = N'(1) << s;
      m_id     = s;
      m_d      = dv[s*W +: W];
      ptr      = (s + 1) % N;
      free_at  = e + HC + 2;
      busy_end = e + HC;
    end
  endtask

  // One clock: inputs already set, model steps at the edge, outputs checked 1ns later.
  task automatic cyc();
    @(posedge clk);
    e++;
    m_edge(req, din);
    #1;
    chk("ld",     ld,     m_ld);
    chk("gnt",    gnt,    m_gnt);
    chk("gnt_id", gnt_id, m_id);
    chk("d",      d,      m_d);
    chk("busy",   busy,   (e <= busy_end));
    chk("q",      q_reg,  m_q);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    #1;
    chk("rst_ld",     ld,     0);
    chk("rst_gnt",    gnt,    0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_d",      d,      0);
    chk("rst_busy",   busy,   0);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int           g_e[$];
  int           g_id[$];
  int           nld;
  int           exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    e = 0;
    m_reset();
    #3;
    do_reset();

    // Single request from requester 2.
    req = 4'b0100;
    din = '0;
    din[2*W +: W] = 16'hBEEF;
    cyc();
    chk("single_ld",  ld,     1);
    chk("single_gnt", gnt,    4'b0100);
    chk("single_id",  gnt_id, 2);
    chk("single_d",   d,      16'hBEEF);
    req = '0;
    cyc();
    chk("single_q",   q_reg,  16'hBEEF);
    chk("single_ld0", ld,     0);
    repeat (3) cyc();

    // All requesting from reset: order 0,1,2,3,0, four cycles apart.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < N; k++) din[k*W +: W] = W'(16'h1000 + k);
    g_e.delete();
    g_id.delete();
    for (int c = 0; c < 18; c++) begin
      cyc();
      if (ld) begin
        g_e.push_back(e);
        g_id.push_back(int'(gnt_id));
      end
    end
    chk("all_count", g_id.size(), 5);
    for (int k = 0; k < 5 && k < g_id.size(); k++) begin
      chk("all_order", g_id[k], exp_order[k]);
      if (k > 0) chk("all_gap", g_e[k] - g_e[k-1], HC + 2);
    end
    req = '0;
    repeat (4) cyc();

    // Pointer wrap: grant 3, then 0, then pointer sits at 1.
    do_reset();
    req = 4'b1000;
    cyc();
    chk("wrap_g3", gnt, 4'b1000);
    req = '0;
    repeat (3) cyc();
    req = 4'b0001;
    cyc();
    chk("wrap_g0", gnt, 4'b0001);
    req = '0;
    repeat (3) cyc();
    req = 4'b0011;
    cyc();
    chk("wrap_ptr1", gnt_id, 1);
    req = '0;
    repeat (4) cyc();

    // din changes after the grant edge must not reach d.
    do_reset();
    din[1*W +: W] = 16'h1234;
    req = 4'b0010;
    cyc();
    req = '0;
    cyc();
    din[1*W +: W] = 16'h5678;
    cyc();
    chk("mid_d",  d,  16'h1234);
    chk("mid_ld", ld, 0);
    repeat (3) cyc();

    // Reset during the GRANT cycle.
    req = 4'b0001;
    cyc();
    chk("rg_pre_ld", ld, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rg_ld",  ld,  0);
    chk("rg_gnt", gnt, 0);
    chk("rg_d",   d,   0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    req = 4'b0110;
    cyc();
    chk("rg_first", gnt, 4'b0010);
    req = '0;
    repeat (4) cyc();

    // A request pulse seen only during HOLD is ignored.
    req = 4'b0001;
    cyc();
    req = '0;
    cyc();
    req = 4'b0100;
    cyc();
    req = '0;
    nld = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (ld) nld++;
    end
    chk("late_nogrant", nld, 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0) req = N'($urandom_range(0, (1 << N) - 1));
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0) din[k*W +: W] = W'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
